// File: rtl/mem_rd_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_rd_pkg
// Shared types and constants for the mem_rd_responder slice.
//   state_t     : responder FSM state (IDLE / WAIT / DATA), 2-bit encoding
//   TXN_CNT_W   : width of the completed-transaction counter
//   WAIT_CNT_W  : width of the wait-state down-counter
//   WAIT_MAX    : largest legal WAIT_CYCLES value
//   wait_load() : initial down-counter value for a given WAIT_CYCLES
// -----------------------------------------------------------------------------
package mem_rd_pkg;

    localparam int TXN_CNT_W  = 8;
    localparam int WAIT_CNT_W = 4;
    localparam int WAIT_MAX   = (1 << WAIT_CNT_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // The first accepted rd already consumes one wait state, so the counter
    // starts one below WAIT_CYCLES. Zero waits never loads the counter.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int wait_cycles);
        if (wait_cycles > 0)
            return WAIT_CNT_W'(wait_cycles - 1);
        else
            return '0;
    endfunction

endpackage

// File: rtl/mem_rd_responder_if.sv
// -----------------------------------------------------------------------------
// mem_rd_if
// Single-word read handshake between the read controller (master) and the
// responder (slave).
//   rd    : master -> slave  read request / retry strobe
//   ds    : master -> slave  done strobe, closes the transaction
//   addr  : master -> slave  read address, sampled with every rd
//   ws    : slave  -> master wait-state response (registered)
//   rdata : slave  -> master read data (registered, valid in DATA)
// -----------------------------------------------------------------------------
interface mem_rd_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();

    logic              rd;
    logic              ds;
    logic [ADDR_W-1:0] addr;
    logic              ws;
    logic [DATA_W-1:0] rdata;

    modport master (
        output rd, ds, addr,
        input  ws, rdata
    );

    modport slave (
        input  rd, ds, addr,
        output ws, rdata
    );

endinterface

// File: rtl/mem_rd_responder_array.sv
// -----------------------------------------------------------------------------
// mem_rd_array
// 2**ADDR_W x DATA_W register file: one synchronous write port, one
// asynchronous read port. Because the read is combinational, a write and a
// read of the same word in the same cycle returns the old contents.
//   clk     : write clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   raddr   : read address
//   rdata   : read data (combinational)
// -----------------------------------------------------------------------------
module mem_rd_array
    import mem_rd_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage is deliberately left out of reset; a reset would turn the
    // array into flops with a reset tree and the contents are preloaded anyway.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_rd_responder.sv
// -----------------------------------------------------------------------------
// mem_rd_responder
// Target-side responder for the go/rd/ws/ds read handshake. Each accepted rd
// that still needs waiting answers with ws=1 one cycle later; once
// WAIT_CYCLES waits are spent the next rd loads rdata from the internal
// register file and holds it until ds closes the transaction.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : mem_rd_if slave modport (rd, ds, addr in; ws, rdata out)
//   wr_en     : preload write enable (any state)
//   wr_addr   : preload write address
//   wr_data   : preload write data
//   proto_err : one-cycle pulse after a cycle with a protocol violation
//   txn_cnt   : completed-transaction count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module mem_rd_responder
    import mem_rd_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_rd_if.slave              bus,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 proto_err,
    output logic [TXN_CNT_W-1:0] txn_cnt
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait_cycles
        $error("mem_rd_responder: WAIT_CYCLES=%0d outside 0..%0d",
               WAIT_CYCLES, WAIT_MAX);
    end

    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q,   cnt_d;
    logic [ADDR_W-1:0]     addr_q,  addr_d;
    logic                  ws_q,    ws_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q,   err_d;
    logic [TXN_CNT_W-1:0]  txn_q,   txn_d;

    logic [ADDR_W-1:0]     mem_raddr;
    logic [DATA_W-1:0]     mem_rdata;

    // In IDLE the zero-wait read must use the live address; afterwards the
    // latched address is authoritative even if the initiator changes addr.
    assign mem_raddr = (state_q == ST_IDLE) ? bus.addr : addr_q;

    mem_rd_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .raddr   (mem_raddr),
        .rdata   (mem_rdata)
    );

    // NOTE: every *_d gets a default before the case statement so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ws_d    = 1'b0;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        txn_d   = txn_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.ds)
                    err_d = 1'b1;
                if (bus.rd) begin
                    addr_d = bus.addr;
                    if (WAIT_CYCLES == 0) begin
                        rdata_d = mem_rdata;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        ws_d    = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (bus.ds)
                    err_d = 1'b1;
                if (bus.rd) begin
                    if (bus.addr != addr_q)
                        err_d = 1'b1;
                    if (cnt_q == '0) begin
                        rdata_d = mem_rdata;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        ws_d  = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                // A simultaneous rd is a violation but never a new request.
                if (bus.rd)
                    err_d = 1'b1;
                if (bus.ds) begin
                    txn_d   = txn_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ws_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ws_q    <= ws_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
        end
    end

    assign bus.ws    = ws_q;
    assign bus.rdata = rdata_q;
    assign proto_err = err_q;
    assign txn_cnt   = txn_q;

endmodule

// File: tb/tb_mem_rd_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_rd_responder
// Directed bench for mem_rd_responder. Two instances share clock, reset and
// the preload port: dut2 with WAIT_CYCLES=2 and dut0 with WAIT_CYCLES=0.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, so a value observed after step() is the result of that edge.
// -----------------------------------------------------------------------------
module tb_mem_rd_responder;
    import mem_rd_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [7:0]           wr_data;
    logic                 err2, err0;
    logic [TXN_CNT_W-1:0] cnt2, cnt0;

    int n_vec = 0;
    int n_err = 0;

    mem_rd_if #(.ADDR_W(4), .DATA_W(8)) bus2 ();
    mem_rd_if #(.ADDR_W(4), .DATA_W(8)) bus0 ();

    mem_rd_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .proto_err (err2),
        .txn_cnt   (cnt2)
    );

    mem_rd_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .proto_err (err0),
        .txn_cnt   (cnt0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rd2(input logic [3:0] a);
        bus2.rd   = 1'b1;
        bus2.addr = a;
        step();
        bus2.rd   = 1'b0;
    endtask

    // Full WAIT_CYCLES=2 transaction with no initiator stalls; ds is issued
    // in the first DATA cycle.
    task automatic run_txn2(input logic [3:0] a);
        rd2(a);
        step();
        rd2(a);
        step();
        rd2(a);
        bus2.ds = 1'b1;
        step();
        bus2.ds = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bus2.rd = 1'b0; bus2.ds = 1'b0; bus2.addr = '0;
        bus0.rd = 1'b0; bus0.ds = 1'b0; bus0.addr = '0;
        step();
        step();
        n_vec++; if (bus2.ws !== 1'b0) begin n_err++; $display("FAIL reset_ws: got %b want 0", bus2.ws); end
        n_vec++; if (bus2.rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", bus2.rdata); end
        n_vec++; if (err2 !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err2); end
        n_vec++; if (cnt2 !== 8'd0) begin n_err++; $display("FAIL reset_txn: got %0d want 0", cnt2); end
        n_vec++; if (bus0.rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata0: got %h want 00", bus0.rdata); end
        rst = 1'b0;
    endtask

    task automatic test_basic_wait2();
        preload(4'd3, 8'hA5);
        bus2.rd = 1'b1; bus2.addr = 4'd3;
        step();                                 // cycle 1
        n_vec++; if (bus2.ws !== 1'b1) begin n_err++; $display("FAIL basic_ws_c1: got %b want 1", bus2.ws); end
        bus2.rd = 1'b0;
        step();                                 // cycle 2
        n_vec++; if (bus2.ws !== 1'b0) begin n_err++; $display("FAIL basic_ws_c2: got %b want 0", bus2.ws); end
        bus2.rd = 1'b1;
        step();                                 // cycle 3
        n_vec++; if (bus2.ws !== 1'b1) begin n_err++; $display("FAIL basic_ws_c3: got %b want 1", bus2.ws); end
        bus2.rd = 1'b0;
        step();                                 // cycle 4
        bus2.rd = 1'b1;
        step();                                 // cycle 5
        bus2.rd = 1'b0;
        n_vec++; if (bus2.ws !== 1'b0) begin n_err++; $display("FAIL basic_ws_c5: got %b want 0", bus2.ws); end
        n_vec++; if (bus2.rdata !== 8'hA5) begin n_err++; $display("FAIL basic_rdata_c5: got %h want a5", bus2.rdata); end
        step();                                 // cycle 6
        n_vec++; if (bus2.rdata !== 8'hA5) begin n_err++; $display("FAIL basic_rdata_hold: got %h want a5", bus2.rdata); end
        n_vec++; if (cnt2 !== 8'd0) begin n_err++; $display("FAIL basic_txn_before_ds: got %0d want 0", cnt2); end
        bus2.ds = 1'b1;
        step();                                 // cycle 7
        bus2.ds = 1'b0;
        n_vec++; if (cnt2 !== 8'd1) begin n_err++; $display("FAIL basic_txn: got %0d want 1", cnt2); end
        n_vec++; if (err2 !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b want 0", err2); end
    endtask

    task automatic test_zero_wait();
        preload(4'd0, 8'h3C);
        bus0.rd = 1'b1; bus0.addr = 4'd0;
        step();
        bus0.rd = 1'b0;
        n_vec++; if (bus0.ws !== 1'b0) begin n_err++; $display("FAIL zw_ws: got %b want 0", bus0.ws); end
        n_vec++; if (bus0.rdata !== 8'h3C) begin n_err++; $display("FAIL zw_rdata: got %h want 3c", bus0.rdata); end
        bus0.ds = 1'b1;
        step();
        bus0.ds = 1'b0;
        n_vec++; if (cnt0 !== 8'd1) begin n_err++; $display("FAIL zw_txn: got %0d want 1", cnt0); end
        n_vec++; if (bus0.ws !== 1'b0) begin n_err++; $display("FAIL zw_ws_after: got %b want 0", bus0.ws); end
    endtask

    task automatic test_proto_err();
        preload(4'd5, 8'h5A);
        rd2(4'd3);
        n_vec++; if (err2 !== 1'b0) begin n_err++; $display("FAIL pe_first_rd: got %b want 0", err2); end
        step();
        rd2(4'd5);                              // retry with a different address
        n_vec++; if (err2 !== 1'b1) begin n_err++; $display("FAIL pe_addr_pulse: got %b want 1", err2); end
        n_vec++; if (bus2.ws !== 1'b1) begin n_err++; $display("FAIL pe_addr_ws: got %b want 1", bus2.ws); end
        step();
        n_vec++; if (err2 !== 1'b0) begin n_err++; $display("FAIL pe_addr_clear: got %b want 0", err2); end
        rd2(4'd3);
        n_vec++; if (bus2.rdata !== 8'hA5) begin n_err++; $display("FAIL pe_rdata_addr_q: got %h want a5", bus2.rdata); end
        bus2.ds = 1'b1;
        step();                                 // closes txn 2
        n_vec++; if (cnt2 !== 8'd2) begin n_err++; $display("FAIL pe_txn2: got %0d want 2", cnt2); end
        step();                                 // ds still high, now in IDLE
        bus2.ds = 1'b0;
        n_vec++; if (err2 !== 1'b1) begin n_err++; $display("FAIL pe_ds_idle: got %b want 1", err2); end
        step();
        n_vec++; if (err2 !== 1'b0) begin n_err++; $display("FAIL pe_ds_idle_clear: got %b want 0", err2); end
        n_vec++; if (cnt2 !== 8'd2) begin n_err++; $display("FAIL pe_ds_idle_txn: got %0d want 2", cnt2); end
    endtask

    task automatic test_ds_rd_data();
        rd2(4'd3);
        step();
        rd2(4'd3);
        step();
        rd2(4'd3);                              // now in DATA
        bus2.rd = 1'b1; bus2.ds = 1'b1;
        step();
        bus2.rd = 1'b0; bus2.ds = 1'b0;
        n_vec++; if (err2 !== 1'b1) begin n_err++; $display("FAIL dsrd_err: got %b want 1", err2); end
        n_vec++; if (cnt2 !== 8'd3) begin n_err++; $display("FAIL dsrd_txn: got %0d want 3", cnt2); end
        n_vec++; if (bus2.ws !== 1'b0) begin n_err++; $display("FAIL dsrd_not_accepted: got %b want 0", bus2.ws); end
        step();
        n_vec++; if (err2 !== 1'b0) begin n_err++; $display("FAIL dsrd_err_clear: got %b want 0", err2); end
    endtask

    task automatic test_write_in_wait();
        rd2(4'd3);
        preload(4'd3, 8'h11);                   // write while in WAIT
        rd2(4'd3);
        step();
        rd2(4'd3);
        n_vec++; if (bus2.rdata !== 8'h11) begin n_err++; $display("FAIL wiw_rdata: got %h want 11", bus2.rdata); end
        bus2.ds = 1'b1;
        step();
        bus2.ds = 1'b0;
        n_vec++; if (cnt2 !== 8'd4) begin n_err++; $display("FAIL wiw_txn: got %0d want 4", cnt2); end
        // write and final read of the same word in the same cycle
        rd2(4'd3);
        step();
        rd2(4'd3);
        step();
        bus2.rd = 1'b1; bus2.addr = 4'd3;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h22;
        step();
        bus2.rd = 1'b0; wr_en = 1'b0;
        n_vec++; if (bus2.rdata !== 8'h11) begin n_err++; $display("FAIL rbw_old: got %h want 11", bus2.rdata); end
        bus2.ds = 1'b1;
        step();
        bus2.ds = 1'b0;
        run_txn2(4'd3);
        n_vec++; if (bus2.rdata !== 8'h22) begin n_err++; $display("FAIL rbw_new: got %h want 22", bus2.rdata); end
        n_vec++; if (cnt2 !== 8'd6) begin n_err++; $display("FAIL rbw_txn: got %0d want 6", cnt2); end
    endtask

    task automatic test_reset_mid();
        rd2(4'd3);
        n_vec++; if (bus2.ws !== 1'b1) begin n_err++; $display("FAIL rm_in_wait: got %b want 1", bus2.ws); end
        rst = 1'b1;
        #1;
        n_vec++; if (bus2.ws !== 1'b0) begin n_err++; $display("FAIL rm_ws: got %b want 0", bus2.ws); end
        n_vec++; if (bus2.rdata !== 8'h00) begin n_err++; $display("FAIL rm_rdata: got %h want 00", bus2.rdata); end
        n_vec++; if (cnt2 !== 8'd0) begin n_err++; $display("FAIL rm_txn: got %0d want 0", cnt2); end
        #1;
        rst = 1'b0;
        run_txn2(4'd3);
        n_vec++; if (bus2.rdata !== 8'h22) begin n_err++; $display("FAIL rm_after_rdata: got %h want 22", bus2.rdata); end
        n_vec++; if (cnt2 !== 8'd1) begin n_err++; $display("FAIL rm_after_txn: got %0d want 1", cnt2); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 255; i++)
            run_txn2(4'd3);
        n_vec++; if (cnt2 !== 8'd255) begin n_err++; $display("FAIL b2b_255: got %0d want 255", cnt2); end
        run_txn2(4'd3);
        n_vec++; if (cnt2 !== 8'd0) begin n_err++; $display("FAIL b2b_wrap: got %0d want 0", cnt2); end
        n_vec++; if (err2 !== 1'b0) begin n_err++; $display("FAIL b2b_err: got %b want 0", err2); end
    endtask

    initial begin
        test_reset();
        test_basic_wait2();
        test_zero_wait();
        test_proto_err();
        test_ds_rd_data();
        test_write_in_wait();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
